// File: rtl/efpga_config_sequencer.sv
// Turns the 32-bit configuration word stream into full-height eFPGA frames:
// sync detection, column header decode, row assembly and frame strobe generation.
module efpga_config_sequencer #(
  parameter int unsigned NUM_ROWS       = 16,
  parameter int unsigned NUM_COLUMNS    = 16,
  parameter int unsigned FRAMES_PER_COL = 20,
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  localparam int unsigned COL_W   = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
  localparam int unsigned FRM_W   = (FRAMES_PER_COL > 1) ? $clog2(FRAMES_PER_COL) : 1,
  localparam int unsigned ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned FRAME_W = 32 * NUM_ROWS
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [31:0]        word_i,
  input  logic               word_strobe_i,
  output logic [FRAME_W-1:0] frame_data_o,
  output logic [COL_W-1:0]   col_select_o,
  output logic [FRM_W-1:0]   frame_select_o,
  output logic               frame_strobe_o,
  output logic               synced_o,
  output logic               error_o
);

  typedef enum logic [1:0] {
    UNSYNCED = 2'd0,
    HEADER   = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam logic [8:0]       COL_LIMIT = 9'(NUM_COLUMNS);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [FRM_W-1:0] LAST_FRM  = FRM_W'(FRAMES_PER_COL - 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] asm_q, asm_d, asm_next;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [FRAME_W-1:0] frame_data_q, frame_data_d;
  logic [COL_W-1:0]   col_sel_q, col_sel_d;
  logic [FRM_W-1:0]   frame_sel_q, frame_sel_d;
  logic               strobe_q, strobe_d;
  logic               error_q, error_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= UNSYNCED;
      asm_q        <= '0;
      row_q        <= '0;
      frm_q        <= '0;
      col_q        <= '0;
      frame_data_q <= '0;
      col_sel_q    <= '0;
      frame_sel_q  <= '0;
      strobe_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      asm_q        <= asm_d;
      row_q        <= row_d;
      frm_q        <= frm_d;
      col_q        <= col_d;
      frame_data_q <= frame_data_d;
      col_sel_q    <= col_sel_d;
      frame_sel_q  <= frame_sel_d;
      strobe_q     <= strobe_d;
      error_q      <= error_d;
    end
  end

  // Oldest word ends up in the MSBs once a full frame has been shifted in.
  assign asm_next = (asm_q << 32) | FRAME_W'(word_i);

  always_comb begin
    state_d      = state_q;
    asm_d        = asm_q;
    row_d        = row_q;
    frm_d        = frm_q;
    col_d        = col_q;
    frame_data_d = frame_data_q;
    col_sel_d    = col_sel_q;
    frame_sel_d  = frame_sel_q;
    strobe_d     = 1'b0;
    error_d      = error_q;

    if (word_strobe_i) begin
      case (state_q)
        UNSYNCED: begin
          if (word_i == SYNC_WORD) begin
            state_d = HEADER;
            error_d = 1'b0;
          end
        end
        HEADER: begin
          if (word_i[31]) begin
            state_d = UNSYNCED;
          end else if ({1'b0, word_i[7:0]} >= COL_LIMIT) begin
            error_d = 1'b1;
            state_d = UNSYNCED;
          end else begin
            col_d   = word_i[COL_W-1:0];
            row_d   = '0;
            frm_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          asm_d = asm_next;
          if (row_q == LAST_ROW) begin
            frame_data_d = asm_next;
            col_sel_d    = col_q;
            frame_sel_d  = frm_q;
            strobe_d     = 1'b1;
            row_d        = '0;
            // After the last frame of a column the next word is a fresh header.
            if (frm_q == LAST_FRM) begin
              frm_d   = '0;
              state_d = HEADER;
            end else begin
              frm_d = frm_q + FRM_W'(1);
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
        default: state_d = UNSYNCED;
      endcase
    end
  end

  assign frame_data_o   = frame_data_q;
  assign col_select_o   = col_sel_q;
  assign frame_select_o = frame_sel_q;
  assign frame_strobe_o = strobe_q;
  assign synced_o       = (state_q != UNSYNCED);
  assign error_o        = error_q;

endmodule

// File: tb/tb_efpga_config_sequencer.sv
// Directed bench for efpga_config_sequencer: sync/header handling, frame
// assembly (back-to-back and gapped), held outputs, error and reset behaviour.
module tb_efpga_config_sequencer;

  localparam int NUM_ROWS       = 16;
  localparam int NUM_COLUMNS    = 16;
  localparam int FRAMES_PER_COL = 20;
  localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;
  localparam int FW = 32 * NUM_ROWS;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [31:0]   word_i;
  logic          word_strobe_i;
  logic [FW-1:0] frame_data_o;
  logic [3:0]    col_select_o;
  logic [4:0]    frame_select_o;
  logic          frame_strobe_o;
  logic          synced_o;
  logic          error_o;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0]   frameWords [NUM_ROWS];
  logic [FW-1:0] lastFrame;
  logic [3:0]    lastCol;
  logic [4:0]    lastFsel;

  efpga_config_sequencer #(
    .NUM_ROWS(NUM_ROWS),
    .NUM_COLUMNS(NUM_COLUMNS),
    .FRAMES_PER_COL(FRAMES_PER_COL),
    .SYNC_WORD(SYNC_WORD)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .word_i(word_i),
    .word_strobe_i(word_strobe_i),
    .frame_data_o(frame_data_o),
    .col_select_o(col_select_o),
    .frame_select_o(frame_select_o),
    .frame_strobe_o(frame_strobe_o),
    .synced_o(synced_o),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of input, then land just after the capturing edge.
  task automatic applyStimulus(input logic [31:0] w, input logic s);
    word_i        = w;
    word_strobe_i = s;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_frame_data", frame_data_o, '0);
    checkOutput("rst_col", FW'(col_select_o), '0);
    checkOutput("rst_fsel", FW'(frame_select_o), '0);
    checkOutput("rst_strobe", FW'(frame_strobe_o), '0);
    checkOutput("rst_synced", FW'(synced_o), '0);
    checkOutput("rst_error", FW'(error_o), '0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_strobe"}, FW'(frame_strobe_o), '0);
    checkOutput({tag, "_held_data"}, frame_data_o, lastFrame);
    checkOutput({tag, "_held_col"}, FW'(col_select_o), FW'(lastCol));
    checkOutput({tag, "_held_fsel"}, FW'(frame_select_o), FW'(lastFsel));
  endtask

  // gapSeed < 0: back-to-back; otherwise 0..5 idle cycles before each word.
  task automatic sendFrame(input logic [3:0] col, input logic [4:0] fsel, input int gapSeed);
    logic [FW-1:0] expFrame;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (gapSeed >= 0) begin
        for (int g = 0; g < (r + gapSeed) % 6; g++) begin
          applyStimulus(32'hDEAD_BEEF, 1'b0);
          checkQuiet("idle");
        end
      end
      applyStimulus(frameWords[r], 1'b1);
      if (r == NUM_ROWS - 1) begin
        expFrame = '0;
        for (int rr = 0; rr < NUM_ROWS; rr++)
          expFrame[(NUM_ROWS - 1 - rr) * 32 +: 32] = frameWords[rr];
        checkOutput("frame_strobe", FW'(frame_strobe_o), FW'(1'b1));
        checkOutput("frame_data", frame_data_o, expFrame);
        checkOutput("frame_col", FW'(col_select_o), FW'(col));
        checkOutput("frame_fsel", FW'(frame_select_o), FW'(fsel));
        lastFrame = expFrame;
        lastCol   = col;
        lastFsel  = fsel;
      end else begin
        checkQuiet("assembling");
      end
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    word_i        = '0;
    word_strobe_i = 1'b0;
    lastFrame     = '0;
    lastCol       = '0;
    lastFsel      = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkReset();
    reset_i = 1'b0;

    $display("[TB] back-to-back column 3");
    applyStimulus(SYNC_WORD, 1'b1);
    checkOutput("sync_synced", FW'(synced_o), FW'(1'b1));
    applyStimulus(32'h0000_0003, 1'b1);
    checkOutput("hdr3_synced", FW'(synced_o), FW'(1'b1));
    checkOutput("hdr3_error", FW'(error_o), '0);
    for (int k = 0; k < FRAMES_PER_COL; k++) begin
      for (int r = 0; r < NUM_ROWS; r++) frameWords[r] = 32'(16 * k + r);
      sendFrame(4'd3, 5'(k), -1);
    end
    checkOutput("col3_end_synced", FW'(synced_o), FW'(1'b1));

    $display("[TB] gapped column 5, header right after last frame");
    applyStimulus(32'h0000_0005, 1'b1);
    checkQuiet("hdr5");
    for (int k = 0; k < FRAMES_PER_COL; k++) begin
      for (int r = 0; r < NUM_ROWS; r++) frameWords[r] = 32'(16 * k + r);
      sendFrame(4'd5, 5'(k), k);
    end
    applyStimulus(32'h0, 1'b0);
    checkQuiet("post_col5");

    $display("[TB] desync header");
    applyStimulus(32'h8000_0000, 1'b1);
    checkOutput("desync_synced", FW'(synced_o), '0);
    checkOutput("desync_error", FW'(error_o), '0);

    $display("[TB] junk before sync");
    applyStimulus(32'h1234_5678, 1'b1);
    checkOutput("junk1_synced", FW'(synced_o), '0);
    checkQuiet("junk1");
    applyStimulus(32'hFAB0_FAB0, 1'b1);
    checkOutput("junk2_synced", FW'(synced_o), '0);
    checkQuiet("junk2");
    applyStimulus(SYNC_WORD, 1'b1);
    checkOutput("resync_synced", FW'(synced_o), FW'(1'b1));

    $display("[TB] bad column header");
    applyStimulus(32'h0000_0010, 1'b1);
    checkOutput("badcol_error", FW'(error_o), FW'(1'b1));
    checkOutput("badcol_synced", FW'(synced_o), '0);
    applyStimulus(32'h0000_0003, 1'b1);
    checkOutput("sticky_error", FW'(error_o), FW'(1'b1));
    checkOutput("sticky_synced", FW'(synced_o), '0);
    applyStimulus(SYNC_WORD, 1'b1);
    checkOutput("clear_error", FW'(error_o), '0);
    checkOutput("clear_synced", FW'(synced_o), FW'(1'b1));

    $display("[TB] column 15 with ignored high bits, sync word as data");
    applyStimulus(32'h7FFF_FF0F, 1'b1);
    checkOutput("hdr15_synced", FW'(synced_o), FW'(1'b1));
    checkOutput("hdr15_error", FW'(error_o), '0);
    for (int r = 0; r < NUM_ROWS; r++) frameWords[r] = 32'hA000_0000 + 32'(r);
    frameWords[8] = SYNC_WORD;
    sendFrame(4'd15, 5'd0, -1);

    $display("[TB] reset mid-frame");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(32'hB000_0000 + 32'(r), 1'b1);
      checkQuiet("partial");
    end
    reset_i = 1'b1;
    #2;
    checkReset();
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    lastFrame = '0;
    lastCol   = '0;
    lastFsel  = '0;
    checkReset();
    for (int r = 8; r < NUM_ROWS; r++) begin
      applyStimulus(32'hB000_0000 + 32'(r), 1'b1);
      checkQuiet("post_reset_drop");
      checkOutput("post_reset_synced", FW'(synced_o), '0);
    end

    $display("[TB] fresh frame after reset");
    applyStimulus(SYNC_WORD, 1'b1);
    applyStimulus(32'h0000_0002, 1'b1);
    checkOutput("hdr2_synced", FW'(synced_o), FW'(1'b1));
    for (int r = 0; r < NUM_ROWS; r++) frameWords[r] = 32'hC000_0000 + 32'(r);
    sendFrame(4'd2, 5'd0, -1);
    applyStimulus(32'h0, 1'b0);
    checkQuiet("final");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
